// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encodings and legal width range.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// Single-bit full adder cell; the only arithmetic element of the serial adder.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one fulladder cell, carry held in a flop between bits,
// operands consumed LSB first, result valid with a one-cycle done pulse.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; outputs hold last result
//   ST_SHIFT | adding one bit pair per clock, busy=1
//   ST_DONE  | done=1 for one cycle; start here reloads with no gap cycle
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    generate
        if (!width_legal(WIDTH)) begin : g_bad_width
            $error("serial_adder: WIDTH out of legal range");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             c_ff;
    logic [CNT_W-1:0] cnt;

    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_next;

    fulladder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (c_ff),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New sum bit enters at the MSB so after WIDTH shifts the LSB sits at bit 0.
    assign sum_next = {fa_sum, sum_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum_out <= '0;
            cout    <= 1'b0;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            c_ff    <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        c_ff  <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    sum_sr <= sum_next;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    c_ff   <= fa_carry;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        sum_out <= sum_next;
                        cout    <= fa_carry;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 scenarios plus an exhaustive WIDTH=2 sweep.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       start;
    logic [7:0] a_in, b_in;
    logic       cin;
    logic       busy, done;
    logic [7:0] sum_out;
    logic       cout;

    logic       start2;
    logic [1:0] a2, b2;
    logic       cin2;
    logic       busy2, done2;
    logic [1:0] sum2;
    logic       cout2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
        .busy(busy), .done(done), .sum_out(sum_out), .cout(cout)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a_in(a2), .b_in(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum_out(sum2), .cout(cout2)
    );

    // Launch one WIDTH=8 add; returns one negedge after the accepting edge with start dropped.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        a_in = a; b_in = b; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a_in = 8'hA5; b_in = 8'hC3; cin = ~c;
    endtask

    // Waits for done; n is the number of negedges waited, or -1 on timeout.
    task automatic wait_done8(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, sum_out, cout} !== 11'd0) begin
            errors++;
            $display("FAIL reset8: busy=%b done=%b sum=%h cout=%b, want all zero", busy, done, sum_out, cout);
        end
        checks++;
        if ({busy2, done2, sum2, cout2} !== 5'd0) begin
            errors++;
            $display("FAIL reset2: busy=%b done=%b sum=%h cout=%b, want all zero", busy2, done2, sum2, cout2);
        end
    endtask

    task automatic test_basic;
        @(negedge clk);
        a_in = 8'h5A; b_in = 8'h3C; cin = 1'b0; start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0; a_in = 8'hFF; b_in = 8'hFF; cin = 1'b1;
            checks++;
            if (busy !== 1'b1 || done !== 1'b0 || sum_out !== 8'h00) begin
                errors++;
                $display("FAIL basic_busy[%0d]: busy=%b done=%b sum=%h, want busy=1 done=0 sum=00", i, busy, done, sum_out);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sum_out !== 8'h96 || cout !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b sum=%h cout=%b, want 1 0 96 0", done, busy, sum_out, cout);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || sum_out !== 8'h96) begin
            errors++;
            $display("FAIL basic_pulse: done=%b sum=%h, want done=0 sum=96", done, sum_out);
        end
    endtask

    task automatic test_overflow;
        int n;
        launch8(8'hFF, 8'h01, 1'b0);
        wait_done8(n);
        checks++;
        if (n !== 8 || sum_out !== 8'h00 || cout !== 1'b1) begin
            errors++;
            $display("FAIL ovf_ff_01: wait=%0d sum=%h cout=%b, want 8 00 1", n, sum_out, cout);
        end
        launch8(8'hFF, 8'hFF, 1'b1);
        wait_done8(n);
        checks++;
        if (n !== 8 || sum_out !== 8'hFF || cout !== 1'b1) begin
            errors++;
            $display("FAIL ovf_ff_ff_c: wait=%0d sum=%h cout=%b, want 8 ff 1", n, sum_out, cout);
        end
    endtask

    task automatic test_start_ignored;
        int pulses = 0;
        logic [7:0] got = 8'h00;
        logic       gotc = 1'b0;
        launch8(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a_in = 8'h01; b_in = 8'h01; cin = 1'b0; start = 1'b1;
        checks++;
        if (busy !== 1'b1 || sum_out !== 8'hFF || cout !== 1'b1) begin
            errors++;
            $display("FAIL ign_hold: busy=%b sum=%h cout=%b, want 1 ff 1", busy, sum_out, cout);
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (done === 1'b1) begin
                pulses++;
                got = sum_out; gotc = cout;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses !== 1 || got !== 8'h46 || gotc !== 1'b0) begin
            errors++;
            $display("FAIL ign_result: pulses=%0d sum=%h cout=%b, want 1 46 0", pulses, got, gotc);
        end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        launch8(8'h77, 8'h11, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, sum_out, cout} !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid: busy=%b done=%b sum=%h cout=%b, want all zero", busy, done, sum_out, cout);
        end
        start = 1'b1; a_in = 8'h01; b_in = 8'h02;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_wins: busy=%b, want 0", busy);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL rst_no_done: pulses=%0d, want 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        launch8(8'h01, 8'h02, 1'b0);
        wait_done8(n);
        checks++;
        if (n !== 8 || sum_out !== 8'h03 || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: wait=%0d sum=%h cout=%b, want 8 03 0", n, sum_out, cout);
        end
        a_in = 8'h10; b_in = 8'h20; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a_in = 8'hEE; b_in = 8'hEE;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || sum_out !== 8'h03) begin
            errors++;
            $display("FAIL b2b_rebusy: busy=%b done=%b sum=%h, want 1 0 03", busy, done, sum_out);
        end
        wait_done8(n);
        checks++;
        if (n !== 8 || sum_out !== 8'h30 || cout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: wait=%0d sum=%h cout=%b, want 8 30 0", n, sum_out, cout);
        end
    endtask

    task automatic test_width2;
        logic [2:0] exp;
        int n;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 2; c++) begin
                    exp = 3'(a + b + c);
                    @(negedge clk);
                    a2 = 2'(a); b2 = 2'(b); cin2 = c[0]; start2 = 1'b1;
                    @(negedge clk);
                    start2 = 1'b0; a2 = ~2'(a); b2 = ~2'(b); cin2 = ~c[0];
                    n = -1;
                    for (int i = 1; i <= 10; i++) begin
                        @(negedge clk);
                        if (done2 === 1'b1) begin
                            n = i;
                            break;
                        end
                    end
                    checks++;
                    if (n !== 2 || {cout2, sum2} !== exp) begin
                        errors++;
                        $display("FAIL w2 a=%0d b=%0d c=%0d: wait=%0d got=%0d, want wait=2 sum=%0d",
                                 a, b, c, n, {cout2, sum2}, exp);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_width2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
